// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the multicycle controller.
//   - State codes presented on multicycle_ctrl.state
//   - Opcodes the controller accepts (instruction[6:0])
//   - TIMEOUT: the memory wait-count limit
package riscv_ctrl_pkg;

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StFetch  = 3'd1;
   localparam logic [2:0] StDecode = 3'd2;
   localparam logic [2:0] StExec   = 3'd3;
   localparam logic [2:0] StMem    = 3'd4;
   localparam logic [2:0] StWb     = 3'd5;
   localparam logic [2:0] StError  = 3'd6;

   localparam logic [6:0] OpRtype  = 7'b0110011;
   localparam logic [6:0] OpItype  = 7'b0010011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;

   localparam logic [3:0] TIMEOUT = 4'd15;

   function automatic logic opcode_legal(input logic [6:0] op);
      return (op == OpRtype) || (op == OpItype) || (op == OpLoad) ||
             (op == OpStore) || (op == OpBranch);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait counter. Counts cycles a request goes unanswered and flags
// when the count has reached TIMEOUT; it holds there until cleared.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : zero the count (takes priority over count)
//   count     : add one this cycle (saturates at TIMEOUT)
//   expired   : count == TIMEOUT
module mem_wait_timer
   import riscv_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic count,
   output logic expired
);

   logic [3:0] cnt_q;

   assign expired = (cnt_q == TIMEOUT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= 4'd0;
      end else if (clear) begin
         cnt_q <= 4'd0;
      end else if (count && !expired) begin
         cnt_q <= cnt_q + 4'd1;
      end
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V style control FSM: IDLE -> FETCH -> DECODE -> EXEC ->
// (MEM) -> (WB) -> retire. Strobes are decoded from the registered state
// plus same-cycle inputs; state, wait count, err and instret are registered.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   en             : run enable, sampled in IDLE and at retire
//   opcode         : instruction[6:0] from the instruction register
//   branch_taken   : ALU compare result (used in EXEC)
//   mem_ready      : memory completion strobe (used in FETCH/MEM only)
//   mem_req/sel/we : memory request, 0=fetch/1=data, store write
//   ir_load        : latch instruction register
//   pc_write/src   : PC update, 0=PC+4/1=branch target
//   reg_write      : register-file write enable
//   state          : current state code
//   err            : sticky fault
//   instret        : retired-instruction count
module multicycle_ctrl
   import riscv_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [6:0]  opcode,
   input  logic        branch_taken,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_sel,
   output logic        mem_we,
   output logic        ir_load,
   output logic        pc_write,
   output logic        pc_src,
   output logic        reg_write,
   output logic [2:0]  state,
   output logic        err,
   output logic [31:0] instret
);

   logic [2:0]  state_q, state_d;
   logic        err_q;
   logic [31:0] instret_q;
   logic        retire;
   logic        in_access;
   logic        timer_clear;
   logic        timer_count;
   logic        timer_expired;

   assign in_access   = (state_q == StFetch) || (state_q == StMem);
   // Any state change restarts the count, so every entry to FETCH/MEM starts at 0.
   assign timer_clear = !in_access || (state_d != state_q);
   assign timer_count = in_access && !mem_ready;

   mem_wait_timer u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (timer_clear),
      .count   (timer_count),
      .expired (timer_expired)
   );

   always_comb begin
      state_d   = state_q;
      mem_req   = 1'b0;
      mem_sel   = 1'b0;
      mem_we    = 1'b0;
      ir_load   = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 1'b0;
      reg_write = 1'b0;
      retire    = 1'b0;

      case (state_q)
         StIdle: begin
            if (en) state_d = StFetch;
         end
         StFetch: begin
            // Once expired no request is issued, but a late ready still completes.
            mem_req = !timer_expired;
            if (mem_ready) begin
               ir_load  = 1'b1;
               pc_write = 1'b1;
               state_d  = StDecode;
            end else if (timer_expired) begin
               state_d = StError;
            end
         end
         StDecode: begin
            state_d = opcode_legal(opcode) ? StExec : StError;
         end
         StExec: begin
            if (opcode == OpBranch) begin
               pc_write = branch_taken;
               pc_src   = 1'b1;
               retire   = 1'b1;
            end else if ((opcode == OpLoad) || (opcode == OpStore)) begin
               state_d = StMem;
            end else begin
               state_d = StWb;
            end
         end
         StMem: begin
            mem_sel = 1'b1;
            mem_req = !timer_expired;
            mem_we  = (opcode == OpStore) && !timer_expired;
            if (mem_ready) begin
               if (opcode == OpStore) retire = 1'b1;
               else                   state_d = StWb;
            end else if (timer_expired) begin
               state_d = StError;
            end
         end
         StWb: begin
            reg_write = 1'b1;
            retire    = 1'b1;
         end
         StError: begin
            state_d = StError;
         end
         default: begin
            state_d = StError;
         end
      endcase

      if (retire) state_d = en ? StFetch : StIdle;

      // Strobes must be quiet for the whole time reset is high.
      if (rst) begin
         mem_req   = 1'b0;
         mem_sel   = 1'b0;
         mem_we    = 1'b0;
         ir_load   = 1'b0;
         pc_write  = 1'b0;
         pc_src    = 1'b0;
         reg_write = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         err_q     <= 1'b0;
         instret_q <= 32'd0;
      end else begin
         state_q <= state_d;
         err_q   <= err_q || (state_d == StError);
         if (retire) instret_q <= instret_q + 32'd1;
      end
   end

   assign state   = state_q;
   assign err     = err_q;
   assign instret = instret_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: en  in  1  run enable; 0 parks controller in IDLE at next instruction boundary.
REQ-004 SHALL have ports: opcode  in  7  instruction[6:0] from the latched instruction register.
REQ-005 SHALL have ports: branch_taken  in  1  ALU compare result, valid in EXEC.
REQ-006 SHALL have ports: mem_ready  in  1  memory completion strobe for the current request.
REQ-007 SHALL have ports: mem_req  out  1  memory request, held until mem_ready.
REQ-008 SHALL have ports: mem_sel  out  1  0 = instruction fetch, 1 = data access.
REQ-009 SHALL have ports: mem_we  out  1  data write (store).
REQ-010 SHALL have ports: ir_load  out  1  latch instruction register.
REQ-011 SHALL have ports: pc_write  out  1  update PC; pc_src  out  1  0 = PC+4, 1 = branch target.
REQ-012 SHALL have ports: reg_write  out  1  register-file write enable.
REQ-013 SHALL have ports: state  out  3  current state code; err  out  1  sticky fault; instret  out  32  retired-instruction count.

Function
REQ-014 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERROR=6.
REQ-015 IDLE: en=1 -> FETCH, else stay; all strobes 0.
REQ-016 FETCH: mem_req=1, mem_sel=0; on mem_ready: ir_load=1, pc_write=1, pc_src=0 in that same cycle, -> DECODE.
REQ-017 DECODE: one cycle; opcode not in {0110011, 0010011, 0000011, 0100011, 1100011} -> ERROR, else -> EXEC.
REQ-018 EXEC: one cycle; branch -> pc_write=branch_taken, pc_src=1, retire; load/store -> MEM; R/I-ALU -> WB.
REQ-019 MEM: mem_req=1, mem_sel=1, mem_we=1 only for store; on mem_ready: store retires, load -> WB.
REQ-020 WB: reg_write=1 for exactly one cycle, retire.
REQ-021 Retire SHALL increment instret by 1 (wraps 0xFFFFFFFF -> 0), then go to FETCH if en=1, else IDLE.
REQ-022 A 4-bit wait counter SHALL clear on entry to FETCH/MEM and count each cycle mem_ready=0; reaching 15 -> ERROR; no request issued that cycle.
REQ-023 mem_ready arriving on the cycle the counter reaches 15 SHALL win: the access completes normally.
REQ-024 mem_ready outside FETCH/MEM SHALL be ignored.
REQ-025 ERROR SHALL be terminal until rst; err=1, all strobes 0, instret frozen.
REQ-026 en falling mid-instruction SHALL NOT abort it; the instruction completes and retires first.
REQ-027 ir_load, pc_write, pc_src, reg_write, mem_* SHALL be decoded from state plus same-cycle inputs; state, counters and err SHALL be registered.

Reset
REQ-028 rst=1 SHALL immediately force state=IDLE, err=0, instret=0, wait counter=0, all strobes 0, independent of clk.
REQ-029 Reset asserted mid-access SHALL drop mem_req that cycle; no write strobe may be emitted while rst=1.

Structure
REQ-030 State codes, the five opcode constants and TIMEOUT=15 SHALL live in shared package riscv_ctrl_pkg.
REQ-031 The wait counter SHALL be sub-module mem_wait_timer (clear, count, expired); the rest stays flat in one module.

Verification
REQ-032 R-type 0110011, mem_ready after 2 cycles -> states 1,1,1,2,3,5,1; reg_write pulses once; instret=1.
REQ-033 Load 0000011, fetch ready at once, data ready after 3 cycles -> MEM holds mem_sel=1, mem_we=0 for 4 cycles, then WB; instret=1.
REQ-034 Branch 1100011, branch_taken=1 -> EXEC pc_write=1, pc_src=1, next state FETCH, reg_write never set; with branch_taken=0, pc_write=0.
REQ-035 Store, mem_ready never asserted -> ERROR after 15 wait cycles, err=1, mem_req=0; stays in ERROR until rst.
REQ-036 opcode 1111111 -> DECODE->ERROR; rst pulse mid-FETCH -> state=0, instret=0 asynchronously, no clk edge needed.
REQ-037 en=0 during EXEC of ALU op -> WB completes, instret increments, state goes to IDLE; en=1 -> FETCH next cycle.
